fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Fetch sequencer for the IF stage. It owns the program counter and drives the IF-stage `pc_in`. It handles sequential advance, hazard stalls, branch/jump redirects with bubble insertion, halt, and misaligned-target detection. It also produces the valid/flush qualifiers that travel with the fetched instruction into decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- IMEM_DEPTH, 16, instruction memory size in 32-bit words. Used only by the bounds check.
- REDIRECT_BUBBLES, 1, invalid cycles inserted after a redirect. Legal range 1..3.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit requests that the PC be held.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  target PC, sampled when redirect_valid=1.
- halt_req  in  1  stop fetching.
- fetch_pc  out  32  PC presented to the IF stage `pc_in`.
- fetch_en  out  1  a new fetch is issued this cycle.
- if_valid  out  1  the IF-stage output register holds a real instruction.
- flush_if  out  1  one-cycle pulse that kills the in-flight IF instruction.
- err  out  2  sticky error code: 0 none, 1 misaligned target, 2 out-of-bounds.
- state  out  3  FSM state, for debug.
- fetch_count  out  32  number of cycles with fetch_en=1.

Behaviour:
Interface: one clock, `clk`; reset is synchronous and active-high, port `reset`.

Reset values (applied on the clock edge where reset=1):
- fetch_pc=RESET_PC
- fetch_en=0, if_valid=0, flush_if=0
- err=0, fetch_count=0
- state=IDLE

Reset mid-operation overrides everything on that edge.

States:
- IDLE=0, RUN=1, STALL=2, BUBBLE=3, HALT=4.

Per-cycle priority in IDLE/RUN/STALL/BUBBLE:
reset > misaligned redirect > redirect > halt_req > stall > advance.

IDLE:
- Exactly one cycle after reset with fetch_en=0.
- Next state RUN, or HALT if halt_req=1.

RUN:
- fetch_en=1 combinationally.
- Next edge: fetch_pc <= fetch_pc+4, with 32-bit wrap (0xFFFFFFFC -> 0). fetch_count increments.

stall=1 in RUN/STALL:
- Go to or remain in STALL.
- fetch_en=0, fetch_pc held, if_valid held, fetch_count held.
- Return to RUN on the first cycle with stall=0.

Redirect (redirect_valid=1, redirect_pc[1:0]==0), in any state except IDLE:
- Next edge: fetch_pc <= redirect_pc, state <= BUBBLE, bubble counter loaded with REDIRECT_BUBBLES.
- flush_if=1 for exactly one cycle, registered: high in the cycle after the redirect.
- A redirect wins over a simultaneous stall or halt_req.
- A redirect in HALT restarts fetch.

Misaligned redirect (redirect_pc[1:0]!=0):
- err <= 1, state <= HALT, fetch_pc unchanged, flush_if pulses.

BUBBLE:
- fetch_en=1 on the final bubble cycle so the target is fetched. if_valid=0 throughout.
- Counter decrements each cycle. At zero, go to RUN.
- A stall in BUBBLE freezes the counter.
- A new redirect in BUBBLE reloads the counter and the PC.

if_valid:
- Registered: if_valid <= fetch_en & ~flush_next & ~halt_entry.
- When held in STALL, it keeps its value.

HALT:
- fetch_en=0, if_valid=0, fetch_pc held.
- Exits only on a valid aligned redirect (-> BUBBLE) or reset.
- halt_req is level-sensitive and is ignored once in HALT.

err:
- Sticky. The first error wins; a later error does not overwrite it.
- Cleared only by reset.

fetch_count: free-running, wraps at 2^32.

Optional Feature:
FETCH_BOUNDS_CHK_EN
- Defined: in RUN, if fetch_pc+4 >= IMEM_DEPTH*4, the next edge sets err <= 2 (if err==0) and state <= HALT, and the out-of-range PC is never issued. Redirect targets >= IMEM_DEPTH*4 are treated the same way. With the default IMEM_DEPTH=16, the limit is 0x40.
- Not defined: no bounds logic. PC advances freely; the IF stage aliases on pc[5:2]. err never takes value 2.

Test Plan:
1. Reset, then 6 free-running cycles.
   - fetch_pc sequence: 0, 0, 4, 8, 0xC, 0x10.
   - fetch_en=0 in IDLE only; if_valid rises one cycle after the first fetch_en.
   - fetch_count=5.
2. stall=1 for 3 cycles at fetch_pc=0x8.
   - fetch_pc stays 0x8, fetch_en=0, fetch_count frozen.
   - On release, the next PCs are 0xC, 0x10.
3. redirect_valid=1, redirect_pc=0x20, together with stall=1, while fetch_pc=0x10.
   - flush_if pulses one cycle, state=BUBBLE, if_valid=0 for REDIRECT_BUBBLES=1 cycle.
   - Then fetch_pc=0x20, 0x24.
4. redirect_pc=0x22.
   - err=1, state=HALT, fetch_en=0.
   - A later redirect_pc=0x4 resumes at 0x4 with err still 1.
   - reset clears err to 0.
5. halt_req=1 in RUN, then reset asserted mid-BUBBLE after a redirect to 0x8.
   - HALT is entered, fetch_pc is held.
   - reset returns all outputs to the reset values on that edge.
6. With FETCH_BOUNDS_CHK_EN and the default IMEM_DEPTH, run from 0x38.
   - 0x3C is issued, 0x40 is not.
   - err=2, state=HALT.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage fetch sequencer. Owns the program counter and handles
// sequential advance, hazard stalls, redirects with bubble insertion, halt and
// misaligned-target detection.
// Optional feature macro: FETCH_BOUNDS_CHK_EN enables the instruction-memory
// bounds check, which halts with err=2 instead of issuing a PC past the end of
// memory. Without it the PC advances freely and err never reaches 2.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC         = 32'h0000_0000,
    parameter int          IMEM_DEPTH       = 16,
    parameter int          REDIRECT_BUBBLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic [31:0] fetch_pc,
    output logic        fetch_en,
    output logic        if_valid,
    output logic        flush_if,
    output logic [1:0]  err,
    output logic [2:0]  state,
    output logic [31:0] fetch_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        STALL  = 3'd2,
        BUBBLE = 3'd3,
        HALT   = 3'd4
    } state_t;

    localparam logic [1:0] BUBBLE_LOAD = 2'(REDIRECT_BUBBLES);

    // Bad parameter values would silently truncate the bubble counter.
    if (REDIRECT_BUBBLES < 1 || REDIRECT_BUBBLES > 3 || IMEM_DEPTH < 1) begin : g_param_check
        $error("fetch_ctrl: REDIRECT_BUBBLES must be 1..3 and IMEM_DEPTH positive");
    end

    state_t      cur_state;
    state_t      next_state;
    logic [1:0]  bubble_cnt;
    logic [1:0]  bubble_cnt_next;
    logic [31:0] pc_next;
    logic [1:0]  err_next;
    logic        flush_next;
    logic        halt_entry;
    logic        valid_hold;

    logic        active;
    logic        redirect_act;
    logic        halt_act;
    logic        stall_act;
    logic        can_fetch;
    logic        target_misaligned;
    logic        target_oob;
    logic        step_oob;

`ifdef FETCH_BOUNDS_CHK_EN
    localparam logic [32:0] PC_LIMIT = 33'(IMEM_DEPTH) * 33'd4;

    // Targets or sequential steps at or past the end of memory are never issued.
    assign target_oob = ({1'b0, redirect_pc} >= PC_LIMIT);
    assign step_oob   = (({1'b0, fetch_pc} + 33'd4) >= PC_LIMIT);
`else
    assign target_oob = 1'b0;
    assign step_oob   = 1'b0;
`endif

    // Qualify the raw requests by the states in which they have any effect.
    assign active            = (cur_state == RUN) || (cur_state == STALL) || (cur_state == BUBBLE);
    assign redirect_act      = redirect_valid && (cur_state != IDLE);
    assign halt_act          = halt_req && active;
    assign stall_act         = stall && active;
    assign target_misaligned = (redirect_pc[1:0] != 2'b00);
    assign can_fetch         = (cur_state == RUN) || (cur_state == STALL) ||
                               ((cur_state == BUBBLE) && (bubble_cnt == 2'd1));
    assign fetch_en          = can_fetch && !redirect_act && !halt_act && !stall_act;
    assign valid_hold        = stall_act && !redirect_act && !halt_act;
    assign state             = cur_state;

    // Next-state, next-PC and error decode following the per-cycle priority.
    always_comb begin
        next_state      = cur_state;
        bubble_cnt_next = bubble_cnt;
        pc_next         = fetch_pc;
        err_next        = err;
        flush_next      = 1'b0;
        halt_entry      = 1'b0;

        if (cur_state == IDLE) begin
            if (halt_req) begin
                next_state = HALT;
                halt_entry = 1'b1;
            end else begin
                next_state = RUN;
            end
        end else if (redirect_act) begin
            flush_next = 1'b1;
            if (target_misaligned || target_oob) begin
                if (err == 2'd0) begin
                    err_next = target_misaligned ? 2'd1 : 2'd2;
                end
                next_state      = HALT;
                halt_entry      = (cur_state != HALT);
                bubble_cnt_next = 2'd0;
            end else begin
                pc_next         = redirect_pc;
                next_state      = BUBBLE;
                bubble_cnt_next = BUBBLE_LOAD;
            end
        end else if (cur_state == HALT) begin
            next_state = HALT;
        end else if (halt_act) begin
            next_state      = HALT;
            halt_entry      = 1'b1;
            bubble_cnt_next = 2'd0;
        end else if (stall_act) begin
            if (cur_state != BUBBLE) begin
                next_state = STALL;
            end
        end else begin
            if (cur_state == BUBBLE) begin
                bubble_cnt_next = bubble_cnt - 2'd1;
                next_state      = (bubble_cnt == 2'd1) ? RUN : BUBBLE;
            end else begin
                next_state = RUN;
            end
            if (fetch_en) begin
                if (step_oob) begin
                    if (err == 2'd0) begin
                        err_next = 2'd2;
                    end
                    next_state      = HALT;
                    halt_entry      = 1'b1;
                    bubble_cnt_next = 2'd0;
                end else begin
                    pc_next = fetch_pc + 32'd4;
                end
            end
        end
    end

    // State, PC and qualifier registers; synchronous reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state   <= IDLE;
            bubble_cnt  <= 2'd0;
            fetch_pc    <= RESET_PC;
            if_valid    <= 1'b0;
            flush_if    <= 1'b0;
            err         <= 2'd0;
            fetch_count <= 32'd0;
        end else begin
            cur_state   <= next_state;
            bubble_cnt  <= bubble_cnt_next;
            fetch_pc    <= pc_next;
            flush_if    <= flush_next;
            err         <= err_next;
            fetch_count <= fetch_count + {31'd0, fetch_en};
            if (!valid_hold) begin
                if_valid <= fetch_en && !flush_next && !halt_entry;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus randomized stimulus for fetch_ctrl,
// checked every cycle against a cycle-level behavioural model of the fetcher.
// Honours FETCH_BOUNDS_CHK_EN the same way the design does.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          RB       = 1;
    localparam int          LIMIT    = 16 * 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        halt_req = 1'b0;
    logic [31:0] fetch_pc;
    logic        fetch_en;
    logic        if_valid;
    logic        flush_if;
    logic [1:0]  err;
    logic [2:0]  state;
    logic [31:0] fetch_count;

    int total = 0;
    int bad   = 0;

    // Reference model: the fetcher described as modes plus a bubble countdown.
    bit          m_known = 0;
    bit          m_idle, m_halted, m_stalled, m_valid, m_flush;
    int          m_bub;
    logic [31:0] m_pc, m_count;
    logic [1:0]  m_err;

    fetch_ctrl #(.RESET_PC(RESET_PC), .IMEM_DEPTH(16), .REDIRECT_BUBBLES(RB)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt_req(halt_req), .fetch_pc(fetch_pc),
        .fetch_en(fetch_en), .if_valid(if_valid), .flush_if(flush_if), .err(err),
        .state(state), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit oob(input logic [31:0] a);
`ifdef FETCH_BOUNDS_CHK_EN
        return ({1'b0, a} >= 33'(LIMIT));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [2:0] exp_state();
        if (m_idle)    return 3'd0;
        if (m_halted)  return 3'd4;
        if (m_bub > 0) return 3'd3;
        if (m_stalled) return 3'd2;
        return 3'd1;
    endfunction

    function automatic bit exp_fetch_en();
        return !m_idle && !m_halted && !redirect_valid && !halt_req && !stall && (m_bub <= 1);
    endfunction

    task automatic model_step();
        bit fe;
        if (reset) begin
            m_known = 1; m_idle = 1; m_halted = 0; m_stalled = 0; m_valid = 0;
            m_flush = 0; m_bub = 0; m_pc = RESET_PC; m_count = 0; m_err = 0;
        end else if (!m_known) begin
            m_known = 0;
        end else if (m_idle) begin
            m_idle = 0; m_flush = 0; m_valid = 0;
            if (halt_req) m_halted = 1;
        end else begin
            fe = exp_fetch_en();
            m_count = m_count + (fe ? 32'd1 : 32'd0);
            m_flush = redirect_valid;
            if (redirect_valid && (redirect_pc[1:0] != 2'b00 || oob(redirect_pc))) begin
                if (m_err == 0) m_err = (redirect_pc[1:0] != 2'b00) ? 2'd1 : 2'd2;
                m_halted = 1; m_bub = 0; m_stalled = 0; m_valid = 0;
            end else if (redirect_valid) begin
                m_pc = redirect_pc; m_halted = 0; m_bub = RB; m_stalled = 0; m_valid = 0;
            end else if (m_halted) begin
                m_valid = 0;
            end else if (halt_req) begin
                m_halted = 1; m_bub = 0; m_stalled = 0; m_valid = 0;
            end else if (stall) begin
                if (m_bub == 0) m_stalled = 1;
            end else begin
                m_stalled = 0;
                if (m_bub > 0) m_bub--;
                m_valid = fe;
                if (fe && oob(m_pc + 32'd4)) begin
                    if (m_err == 0) m_err = 2'd2;
                    m_halted = 1; m_bub = 0; m_valid = 0;
                end else if (fe) begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, compare at the falling edge, then advance the model.
    task automatic applyStimulus(input bit r, input bit s, input bit rv,
                                 input logic [31:0] rpc, input bit hr);
        reset = r; stall = s; redirect_valid = rv; redirect_pc = rpc; halt_req = hr;
        @(negedge clk);
        if (m_known) begin
            checkOutput("fetch_pc", fetch_pc, m_pc);
            checkOutput("fetch_en", 32'(fetch_en), 32'(exp_fetch_en()));
            checkOutput("if_valid", 32'(if_valid), 32'(m_valid));
            checkOutput("flush_if", 32'(flush_if), 32'(m_flush));
            checkOutput("err", 32'(err), 32'(m_err));
            checkOutput("state", 32'(state), 32'(exp_state()));
            checkOutput("fetch_count", fetch_count, m_count);
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 32'd0, 0);
    endtask

    initial begin
        logic [31:0] rpc;
        int          sel;

        // Reset and free-running sequential fetch.
        applyStimulus(1, 0, 0, 32'd0, 0);
        checkOutput("t1_reset_state", 32'(state), 32'd0);
        checkOutput("t1_reset_pc", fetch_pc, RESET_PC);
        idle_cycles(6);
        checkOutput("t1_pc", fetch_pc, 32'h14);
        checkOutput("t1_count", fetch_count, 32'd5);

        // Stall for three cycles at 0x8.
        applyStimulus(1, 0, 0, 32'd0, 0);
        idle_cycles(3);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 32'd0, 0);
        checkOutput("t2_stall_pc", fetch_pc, 32'h8);
        checkOutput("t2_stall_count", fetch_count, 32'd2);
        idle_cycles(2);
        checkOutput("t2_release_pc", fetch_pc, 32'h10);

        // Redirect wins over simultaneous stall.
        applyStimulus(0, 1, 1, 32'h20, 0);
        checkOutput("t3_bubble", 32'(state), 32'd3);
        checkOutput("t3_flush", 32'(flush_if), 32'd1);
        checkOutput("t3_target", fetch_pc, 32'h20);
        idle_cycles(1);
        checkOutput("t3_next_pc", fetch_pc, 32'h24);
        checkOutput("t3_valid", 32'(if_valid), 32'd1);

        // Misaligned redirect, recovery with sticky err, then reset clears err.
        applyStimulus(0, 0, 1, 32'h22, 0);
        checkOutput("t4_err", 32'(err), 32'd1);
        checkOutput("t4_halt", 32'(state), 32'd4);
        checkOutput("t4_pc_held", fetch_pc, 32'h24);
        idle_cycles(2);
        applyStimulus(0, 0, 1, 32'h4, 0);
        idle_cycles(1);
        checkOutput("t4_resume_pc", fetch_pc, 32'h8);
        checkOutput("t4_err_sticky", 32'(err), 32'd1);
        applyStimulus(1, 0, 0, 32'd0, 0);
        checkOutput("t4_err_clear", 32'(err), 32'd0);

        // halt_req in RUN, redirect out of HALT, reset in the bubble.
        idle_cycles(2);
        applyStimulus(0, 0, 0, 32'd0, 1);
        checkOutput("t5_halt", 32'(state), 32'd4);
        idle_cycles(2);
        checkOutput("t5_pc_held", fetch_pc, 32'h4);
        applyStimulus(0, 0, 1, 32'h8, 0);
        applyStimulus(1, 0, 0, 32'd0, 0);
        checkOutput("t5_reset_state", 32'(state), 32'd0);
        checkOutput("t5_reset_pc", fetch_pc, RESET_PC);
        checkOutput("t5_reset_count", fetch_count, 32'd0);

`ifdef FETCH_BOUNDS_CHK_EN
        // Sequential run into the end of instruction memory.
        idle_cycles(1);
        applyStimulus(0, 0, 1, 32'h38, 0);
        idle_cycles(2);
        checkOutput("t6_err", 32'(err), 32'd2);
        checkOutput("t6_halt", 32'(state), 32'd4);
        checkOutput("t6_pc", fetch_pc, 32'h3C);
        applyStimulus(1, 0, 0, 32'd0, 0);
`endif

        // Randomized traffic, including the 32-bit PC wrap.
        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      rpc = {26'd0, 6'($urandom_range(0, 63))} | 32'd1;
            else if (sel == 1) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
            else               rpc = 32'($urandom_range(0, 15)) * 32'd4;
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 5) == 0, rpc, $urandom_range(0, 24) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
